// File: rtl/rr_resource_scheduler.sv
// rr_resource_scheduler: round-robin owner-holds-until-done arbiter with hold timeout and turnaround gap
module rr_resource_scheduler #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic                     i_res_busy,
    input  logic                     i_done,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_gnt_id,
    output logic                     o_gnt_valid,
    output logic                     o_timeout,
    output logic [15:0]              o_timeout_cnt
);
    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, above, masked, pick, winner;
    logic [IW-1:0]    last_ptr_q, last_ptr_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic             gnt_valid_q, gnt_valid_d, timeout_q, timeout_d;
    logic [15:0]      timeout_cnt_q, timeout_cnt_d;
    logic             release_own, at_limit;

    function automatic logic [IW-1:0] encode(input logic [N_REQ-1:0] oh);
        encode = '0;
        for (int i = 0; i < N_REQ; i++) if (oh[i]) encode = encode | IW'(i);
    endfunction

    // Requests strictly above the last winner take precedence; otherwise wrap to the lowest set bit.
    always_comb begin
        above       = ({N_REQ{1'b1}} << last_ptr_q) << 1;
        masked      = i_req & above;
        pick        = |masked ? masked : i_req;
        winner      = pick & (-pick);
        release_own = i_done || !(|(i_req & gnt_q));
        at_limit    = hold_cnt_q == HW'(MAX_HOLD);
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;
        timeout_cnt_d = timeout_cnt_q;
        case (state_q)
            IDLE: if (|i_req && !i_res_busy) begin
                state_d    = OWN;
                gnt_d      = winner;
                hold_cnt_d = HW'(1);
            end
            OWN: if (release_own || at_limit) begin
                state_d       = GAP;
                gnt_d         = '0;
                hold_cnt_d    = '0;
                timeout_d     = !release_own;
                timeout_cnt_d = (!release_own && timeout_cnt_q != 16'hFFFF) ? timeout_cnt_q + 16'd1 : timeout_cnt_q;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
            default: state_d = IDLE;
        endcase
        gnt_valid_d = |gnt_d;
        // The owner's index is only consulted again in IDLE, so latching it during OWN is early enough.
        last_ptr_d  = (state_q == OWN) ? o_gnt_id : last_ptr_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            gnt_valid_q   <= 1'b0;
            hold_cnt_q    <= '0;
            timeout_q     <= 1'b0;
            timeout_cnt_q <= '0;
            last_ptr_q    <= IW'(N_REQ - 1);
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_valid_q   <= gnt_valid_d;
            hold_cnt_q    <= hold_cnt_d;
            timeout_q     <= timeout_d;
            timeout_cnt_q <= timeout_cnt_d;
            last_ptr_q    <= last_ptr_d;
        end
    end

    assign o_gnt         = gnt_q;
    assign o_gnt_id      = encode(gnt_q);
    assign o_gnt_valid   = gnt_valid_q;
    assign o_timeout     = timeout_q;
    assign o_timeout_cnt = timeout_cnt_q;
endmodule

// File: tb/tb_rr_resource_scheduler.sv
// tb_rr_resource_scheduler: directed scenarios plus randomized run against a behavioural model
module tb_rr_resource_scheduler;
    localparam int N  = 8;
    localparam int MH = 16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  req = '0;
    logic        busy = 1'b0;
    logic        done = 1'b0;
    logic [7:0]  gnt;
    logic [2:0]  gnt_id;
    logic        gnt_valid, to;
    logic [15:0] to_cnt;
    int errors = 0;
    int checks = 0;
    int m_state = 0, m_owner = 0, m_last = N - 1, m_hold = 0, m_tocnt = 0;
    bit m_to = 0;

    rr_resource_scheduler #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_res_busy(busy), .i_done(done),
        .o_gnt(gnt), .o_gnt_id(gnt_id), .o_gnt_valid(gnt_valid),
        .o_timeout(to), .o_timeout_cnt(to_cnt)
    );

    always #5 clk = ~clk;

    function automatic int pick_next(input logic [7:0] r, input int last);
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    // model: 0 idle, 1 owning, 2 turnaround
    task automatic model_step();
        if (!rst_n) begin
            m_state = 0; m_owner = 0; m_last = N - 1; m_hold = 0; m_to = 0; m_tocnt = 0;
        end else begin
            m_to = 0;
            if (m_state == 0) begin
                if (req != 0 && !busy) begin
                    m_owner = pick_next(req, m_last); m_last = m_owner; m_hold = 1; m_state = 1;
                end
            end else if (m_state == 1) begin
                if (done || !req[m_owner]) m_state = 2;
                else if (m_hold == MH) begin
                    m_state = 2; m_to = 1;
                    if (m_tocnt < 65535) m_tocnt++;
                end else m_hold++;
            end else m_state = 0;
        end
    endtask

    function automatic logic [7:0] exp_gnt();
        return (m_state == 1) ? 8'(1 << m_owner) : 8'h00;
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; req = 0; busy = 0; done = 0;
        cycle(); cycle();
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h want 00", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
        checks++; if (gnt_id !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", gnt_id); end
        checks++; if (to !== 1'b0 || to_cnt !== 16'd0) begin errors++; $display("FAIL reset_timeout: got %b/%0d want 0/0", to, to_cnt); end
        rst_n = 1;
        cycle();
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL idle_no_req: got %h want 00", gnt); end
    endtask

    task automatic test_single();
        req = 8'h01;
        cycle();
        checks++; if (gnt !== 8'h01 || gnt_valid !== 1'b1 || gnt_id !== 3'd0) begin errors++; $display("FAIL single_grant: got %h/%b/%0d want 01/1/0", gnt, gnt_valid, gnt_id); end
        cycle(); cycle();
        done = 1;
        cycle();
        done = 0;
        checks++; if (gnt !== 8'h00 || to !== 1'b0) begin errors++; $display("FAIL single_release: got %h/%b want 00/0", gnt, to); end
        cycle();
        checks++; if (gnt !== 8'h00 || to !== 1'b0) begin errors++; $display("FAIL single_gap: got %h/%b want 00/0", gnt, to); end
        cycle();
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL single_regrant: got %h want 01", gnt); end
        req = 0;
        cycle(); cycle();
        checks++; if (gnt !== 8'h00 || to_cnt !== 16'd0) begin errors++; $display("FAIL single_withdraw: got %h/%0d want 00/0", gnt, to_cnt); end
    endtask

    task automatic test_round_robin();
        rst_n = 0; cycle(); rst_n = 1;
        req = 8'hFF;
        for (int k = 0; k <= N; k++) begin
            cycle();
            checks++; if (gnt !== 8'(1 << (k % N)) || gnt_id !== 3'(k % N)) begin errors++; $display("FAIL rr_order_%0d: got %h/%0d want %h/%0d", k, gnt, gnt_id, 8'(1 << (k % N)), k % N); end
            cycle();
            done = 1;
            cycle();
            done = 0;
            checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL rr_gap1_%0d: got %h want 00", k, gnt); end
            cycle();
            checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL rr_gap2_%0d: got %h want 00", k, gnt); end
        end
        req = 0;
        cycle();
    endtask

    task automatic test_wrap();
        rst_n = 0; cycle(); rst_n = 1;
        req = 8'h04;
        cycle();
        checks++; if (gnt !== 8'h04) begin errors++; $display("FAIL wrap_setup: got %h want 04", gnt); end
        req = 0;
        cycle(); cycle();
        req = 8'h24;
        cycle();
        checks++; if (gnt !== 8'h20 || gnt_id !== 3'd5) begin errors++; $display("FAIL wrap_above: got %h/%0d want 20/5", gnt, gnt_id); end
        done = 1;
        cycle();
        done = 0;
        cycle(); cycle();
        checks++; if (gnt !== 8'h04 || gnt_id !== 3'd2) begin errors++; $display("FAIL wrap_around: got %h/%0d want 04/2", gnt, gnt_id); end
        req = 0;
        cycle(); cycle();
    endtask

    task automatic test_timeout();
        int hi;
        rst_n = 0; cycle(); rst_n = 1;
        req = 8'h03;
        cycle();
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL to_grant: got %h want 01", gnt); end
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (gnt == 8'h01) hi++;
            else break;
        end
        checks++; if (hi != MH) begin errors++; $display("FAIL to_hold_len: got %0d want %0d", hi, MH); end
        checks++; if (to !== 1'b1 || to_cnt !== 16'd1) begin errors++; $display("FAIL to_pulse: got %b/%0d want 1/1", to, to_cnt); end
        cycle();
        checks++; if (to !== 1'b0 || gnt !== 8'h00) begin errors++; $display("FAIL to_single_pulse: got %b/%h want 0/00", to, gnt); end
        cycle();
        checks++; if (gnt !== 8'h02) begin errors++; $display("FAIL to_next_owner: got %h want 02", gnt); end
        for (int i = 0; i < MH - 1; i++) cycle();
        done = 1;
        cycle();
        done = 0;
        checks++; if (gnt !== 8'h00 || to !== 1'b0 || to_cnt !== 16'd1) begin errors++; $display("FAIL to_done_at_limit: got %h/%b/%0d want 00/0/1", gnt, to, to_cnt); end
        req = 0;
        cycle(); cycle();
    endtask

    task automatic test_busy_reset();
        rst_n = 0; cycle(); rst_n = 1;
        busy = 1; req = 8'h10;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL busy_block_%0d: got %h want 00", i, gnt); end
        end
        busy = 0;
        cycle();
        checks++; if (gnt !== 8'h10 || gnt_id !== 3'd4) begin errors++; $display("FAIL busy_release: got %h/%0d want 10/4", gnt, gnt_id); end
        busy = 1;
        cycle();
        checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL busy_ignored_in_own: got %h want 10", gnt); end
        busy = 0; rst_n = 0; req = 8'hFF;
        cycle();
        checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0 || to !== 1'b0) begin errors++; $display("FAIL mid_reset: got %h/%b/%b want 00/0/0", gnt, gnt_valid, to); end
        rst_n = 1;
        cycle();
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL post_reset_winner: got %h want 01", gnt); end
        req = 0;
        cycle(); cycle();
    endtask

    task automatic test_random();
        logic [7:0] eg;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = req ^ 8'(1 << $urandom_range(0, 7));
            busy  = ($urandom_range(0, 3) == 0);
            done  = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 149) != 0);
            cycle();
            eg = exp_gnt();
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rand_gnt@%0d: got %h want %h", c, gnt, eg); end
            checks++; if (gnt_valid !== (eg != 0)) begin errors++; $display("FAIL rand_valid@%0d: got %b want %b", c, gnt_valid, eg != 0); end
            if (eg != 0) begin
                checks++; if (gnt_id !== 3'(m_owner)) begin errors++; $display("FAIL rand_id@%0d: got %0d want %0d", c, gnt_id, m_owner); end
            end
            checks++; if (to !== m_to) begin errors++; $display("FAIL rand_timeout@%0d: got %b want %b", c, to, m_to); end
            checks++; if (to_cnt !== 16'(m_tocnt)) begin errors++; $display("FAIL rand_to_cnt@%0d: got %0d want %0d", c, to_cnt, m_tocnt); end
        end
        rst_n = 1; busy = 0; done = 0; req = 0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_busy_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
